// File: rtl/clk_div_multi.sv
// -----------------------------------------------------------------------------
// clk_div_multi
//
// Multi-channel programmable integer clock divider. Each of CH channels
// produces its own divided clock from Ref_CLK:
//   * ratio R >= 2 : divided clock, high = R>>1 cycles, low = R - (R>>1)
//   * ratio R <= 1 : glitch-free bypass, Div_CLK follows Ref_CLK
// A new ratio or a disable request takes effect only at a period boundary,
// which is the end of a low phase. This means a high pulse is never truncated
// and no runt pulse is ever produced. The only exception is an asynchronous
// reset, which may cut a phase short.
//
// Optional feature macro: CLK_DIV_TICK_EN
//   When defined, the Div_Tick port exists. It gives a one-Ref_CLK-cycle
//   registered pulse at every rising edge of a divided Div_CLK. It is never
//   asserted in bypass or idle.
//
// Parameters
//   Width       width of each channel's ratio field
//   CH          number of independent channels
// Ports
//   Ref_CLK     reference clock. All state uses the rising edge, except the
//               bypass-select flop, which uses the falling edge.
//   RST         asynchronous, active-low reset
//   CLK_EN      per-channel enable request
//   div_ratio   packed ratios; channel k uses bits [k*Width +: Width]
//   Div_CLK     divided or bypassed clock per channel
//   Div_Active  1 while the channel is running (divided or bypass), registered
//   Div_Tick    (CLK_DIV_TICK_EN only) pulse coincident with each divided rise
// -----------------------------------------------------------------------------
module clk_div_multi #(
    parameter int Width = 8,
    parameter int CH    = 2
) (
    input  logic                  Ref_CLK,
    input  logic                  RST,
    input  logic [CH-1:0]         CLK_EN,
    input  logic [CH*Width-1:0]   div_ratio,
    output logic [CH-1:0]         Div_CLK,
    output logic [CH-1:0]         Div_Active
`ifdef CLK_DIV_TICK_EN
    ,
    output logic [CH-1:0]         Div_Tick
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_BYP  = 2'd2
    } state_t;

    localparam logic [Width-1:0] RATIO_ONE = Width'(1);

    genvar k;
    generate
        for (k = 0; k < CH; k++) begin : g_ch
            state_t           r_state;
            logic [Width-1:0] r_rs;       // shadow ratio for the running period
            logic [Width-1:0] r_cnt;      // cycle count within the current phase
            logic             r_q;        // divided-clock flop
            logic             r_bsel;     // bypass select, falling-edge domain
            logic             r_active;

            logic [Width-1:0] w_ratio;
            logic [Width-1:0] w_hi_len;
            logic [Width-1:0] w_lo_len;
            logic [Width-1:0] w_new_lo_len;
            logic             w_new_div;
            logic             w_hi_end;
            logic             w_boundary;
            logic             w_q_set;

            assign w_ratio      = div_ratio[k*Width +: Width];
            assign w_hi_len     = r_rs >> 1;
            assign w_lo_len     = r_rs - w_hi_len;
            assign w_new_lo_len = w_ratio - (w_ratio >> 1);
            assign w_new_div    = (w_ratio > RATIO_ONE);

            // Phase ends are decoded from the shadow ratio, so a ratio that
            // changes mid-period cannot disturb the running period.
            assign w_hi_end   = (r_state == S_DIV) && r_q
                                && (r_cnt == w_hi_len - RATIO_ONE);
            assign w_boundary = (r_state == S_DIV) && !r_q
                                && (r_cnt == w_lo_len - RATIO_ONE);

            // q rises at enable from idle, or at a boundary that reloads a
            // divided ratio. Leaving bypass deliberately does not set q.
            assign w_q_set = CLK_EN[k] && w_new_div
                             && ((r_state == S_IDLE) || w_boundary);

            // NOTE: all state below is updated with non-blocking assignments, so
            // every flop samples values from before the edge. Blocking '=' here
            // would make the result depend on statement order.
            always_ff @(posedge Ref_CLK or negedge RST) begin
                if (!RST) begin
                    r_state  <= S_IDLE;
                    r_rs     <= '0;
                    r_cnt    <= '0;
                    r_q      <= 1'b0;
                    r_active <= 1'b0;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            if (CLK_EN[k]) begin
                                r_rs     <= w_ratio;
                                r_cnt    <= '0;
                                r_active <= 1'b1;
                                if (w_new_div) begin
                                    r_state <= S_DIV;
                                    r_q     <= 1'b1;
                                end else begin
                                    r_state <= S_BYP;
                                end
                            end
                        end

                        S_DIV: begin
                            if (w_hi_end) begin
                                r_q   <= 1'b0;
                                r_cnt <= '0;
                            end else if (w_boundary) begin
                                r_cnt <= '0;
                                if (!CLK_EN[k]) begin
                                    r_state  <= S_IDLE;
                                    r_active <= 1'b0;
                                end else begin
                                    r_rs <= w_ratio;
                                    if (w_new_div) begin
                                        r_q <= 1'b1;
                                    end else begin
                                        r_state <= S_BYP;
                                    end
                                end
                            end else begin
                                r_cnt <= r_cnt + RATIO_ONE;
                            end
                        end

                        S_BYP: begin
                            if (!CLK_EN[k]) begin
                                r_state  <= S_IDLE;
                                r_active <= 1'b0;
                            end else if (w_new_div) begin
                                // Hold q low for one cycle. Preloading the
                                // count to the last low-phase cycle makes the
                                // next edge a normal period boundary, and the
                                // first divided rise happens there.
                                r_state <= S_DIV;
                                r_rs    <= w_ratio;
                                r_cnt   <= w_new_lo_len - RATIO_ONE;
                            end
                        end

                        default: begin
                            r_state  <= S_IDLE;
                            r_cnt    <= '0;
                            r_q      <= 1'b0;
                            r_active <= 1'b0;
                        end
                    endcase
                end
            end

            // The select changes only while Ref_CLK is low. At that time both
            // mux inputs are low (q is always 0 around bypass), so switching
            // in or out of bypass cannot produce a partial pulse. The
            // asynchronous clear forces Div_CLK low at once during reset.
            always_ff @(negedge Ref_CLK or negedge RST) begin
                if (!RST) begin
                    r_bsel <= 1'b0;
                end else begin
                    r_bsel <= (r_state == S_BYP);
                end
            end

            assign Div_CLK[k]    = r_bsel ? Ref_CLK : r_q;
            assign Div_Active[k] = r_active;

`ifdef CLK_DIV_TICK_EN
            logic r_tick;

            always_ff @(posedge Ref_CLK or negedge RST) begin
                if (!RST) begin
                    r_tick <= 1'b0;
                end else begin
                    r_tick <= w_q_set;
                end
            end

            assign Div_Tick[k] = r_tick;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// -----------------------------------------------------------------------------
// tb_clk_div_multi
//
// Testbench for clk_div_multi. The reference model works at the level of whole
// periods. At each period boundary it expands the ratio into a queue of
// per-cycle levels (R>>1 ones followed by the remaining zeros). When the queue
// is empty, the next rising edge is a boundary, and the enable and ratio
// decide whether the channel goes idle, divides, or bypasses.
//
// Div_CLK is sampled in both halves of every Ref_CLK cycle:
//   * low half  : the divided level (bypass also reads 0 here)
//   * high half : 1 if the channel was in bypass before this edge (the select
//                 only changes on falling edges), otherwise the divided level
// -----------------------------------------------------------------------------
module tb_clk_div_multi;

    localparam int W  = 8;
    localparam int CH = 2;

    logic            Ref_CLK = 1'b0;
    logic            RST     = 1'b0;
    logic [CH-1:0]   CLK_EN  = '0;
    logic [CH*W-1:0] div_ratio = '0;
    logic [CH-1:0]   Div_CLK;
    logic [CH-1:0]   Div_Active;
`ifdef CLK_DIV_TICK_EN
    logic [CH-1:0]   Div_Tick;
    logic [CH-1:0]   o_tick;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    clk_div_multi #(.Width(W), .CH(CH)) dut (
        .Ref_CLK    (Ref_CLK),
        .RST        (RST),
        .CLK_EN     (CLK_EN),
        .div_ratio  (div_ratio),
        .Div_CLK    (Div_CLK),
`ifdef CLK_DIV_TICK_EN
        .Div_Tick   (Div_Tick),
`endif
        .Div_Active (Div_Active)
    );

    always #5 Ref_CLK = ~Ref_CLK;

    // ---------------------------------------------------------------- model
    typedef enum {M_IDLE, M_DIV, M_BYP} mode_t;

    mode_t         m_mode [CH];
    bit            m_lvl  [CH][$];
    logic [CH-1:0] e_cur, e_was_byp, e_act, e_tick;
    logic [CH-1:0] o_hi, o_lo, o_act;

    function automatic void model_reset();
        for (int k = 0; k < CH; k++) begin
            m_mode[k] = M_IDLE;
            m_lvl[k].delete();
        end
        e_cur = '0; e_was_byp = '0; e_act = '0; e_tick = '0;
    endfunction

    function automatic void model_step();
        for (int k = 0; k < CH; k++) begin
            int r;
            r = int'(div_ratio[k*W +: W]);
            e_was_byp[k] = (m_mode[k] == M_BYP);
            e_tick[k]    = 1'b0;
            if (m_lvl[k].size() != 0) begin
                e_cur[k] = m_lvl[k].pop_front();
            end else if (!CLK_EN[k]) begin
                m_mode[k] = M_IDLE;
                e_cur[k]  = 1'b0;
            end else if (r >= 2 && m_mode[k] == M_BYP) begin
                m_mode[k] = M_DIV;      // one low cycle, then a boundary
                e_cur[k]  = 1'b0;
            end else if (r >= 2) begin
                m_mode[k] = M_DIV;
                for (int i = 0; i < r / 2; i++) m_lvl[k].push_back(1'b1);
                for (int i = 0; i < r - r / 2; i++) m_lvl[k].push_back(1'b0);
                e_cur[k]  = m_lvl[k].pop_front();
                e_tick[k] = 1'b1;
            end else begin
                m_mode[k] = M_BYP;
                e_cur[k]  = 1'b0;
            end
            e_act[k] = (m_mode[k] != M_IDLE);
        end
    endfunction

    function automatic logic [CH-1:0] e_hi();
        return e_was_byp | e_cur;
    endfunction

    function automatic bit model_busy();
        for (int k = 0; k < CH; k++)
            if (m_mode[k] != M_IDLE) return 1'b1;
        return 1'b0;
    endfunction

    // One Ref_CLK cycle: step the model at the rising edge, then sample the
    // high half and the low half. Returns 2 time units after the falling edge,
    // so any inputs driven next change well away from the rising edge.
    task automatic cycle();
        @(posedge Ref_CLK);
        model_step();
        #2;
        o_hi  = Div_CLK;
        o_act = Div_Active;
`ifdef CLK_DIV_TICK_EN
        o_tick = Div_Tick;
`endif
        @(negedge Ref_CLK);
        #2;
        o_lo = Div_CLK;
    endtask

    task automatic set_r(input int k, input int r);
        div_ratio[k*W +: W] = W'(r);
    endtask

    task automatic drain();
        int i;
        CLK_EN = '0;
        i = 0;
        while (model_busy() && i < 600) begin
            cycle();
            i++;
        end
        n_checks++;
        if (model_busy()) begin
            n_fail++;
            $display("FAIL drain: channels still busy after %0d cycles, want idle", i);
        end
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        #1;
        n_checks++;
        if (Div_CLK !== '0) begin
            n_fail++; $display("FAIL reset_clk: got %b want 00", Div_CLK);
        end
        n_checks++;
        if (Div_Active !== '0) begin
            n_fail++; $display("FAIL reset_active: got %b want 00", Div_Active);
        end
`ifdef CLK_DIV_TICK_EN
        n_checks++;
        if (Div_Tick !== '0) begin
            n_fail++; $display("FAIL reset_tick: got %b want 00", Div_Tick);
        end
`endif
        model_reset();
        @(negedge Ref_CLK);
        @(negedge Ref_CLK);
        #2;
        RST = 1'b1;
    endtask

    task automatic test_even_ratio();
        set_r(0, 4);
        CLK_EN = 2'b01;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (i == 0) begin
                n_checks++;
                if (o_hi[0] !== 1'b1 || o_act[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL even_first_rise: clk/act got %b/%b want 1/1", o_hi[0], o_act[0]);
                end
            end
            n_checks++;
            if ({o_hi, o_lo, o_act} !== {e_hi(), e_cur, e_act}) begin
                n_fail++;
                $display("FAIL even cyc %0d: hi/lo/act got %b/%b/%b want %b/%b/%b",
                         i, o_hi, o_lo, o_act, e_hi(), e_cur, e_act);
            end
        end
        drain();
    endtask

    task automatic test_odd_ratio();
        int highs;
        set_r(1, 5);
        CLK_EN = 2'b10;
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            highs += int'(o_lo[1]);
            n_checks++;
            if ({o_hi, o_lo, o_act} !== {e_hi(), e_cur, e_act}) begin
                n_fail++;
                $display("FAIL odd5 cyc %0d: hi/lo/act got %b/%b/%b want %b/%b/%b",
                         i, o_hi, o_lo, o_act, e_hi(), e_cur, e_act);
            end
        end
        n_checks++;
        if (highs != 4) begin
            n_fail++; $display("FAIL odd5_high_cycles: got %0d want 4", highs);
        end
        set_r(1, 2);
        for (int i = 0; i < 8; i++) begin
            cycle();
            n_checks++;
            if ({o_hi, o_lo, o_act} !== {e_hi(), e_cur, e_act}) begin
                n_fail++;
                $display("FAIL ratio2 cyc %0d: hi/lo/act got %b/%b/%b want %b/%b/%b",
                         i, o_hi, o_lo, o_act, e_hi(), e_cur, e_act);
            end
        end
        drain();
        set_r(1, 255);
        CLK_EN = 2'b10;
        highs = 0;
        for (int i = 0; i < 255; i++) begin
            cycle();
            highs += int'(o_lo[1]);
            n_checks++;
            if ({o_hi, o_lo, o_act} !== {e_hi(), e_cur, e_act}) begin
                n_fail++;
                $display("FAIL ratio255 cyc %0d: hi/lo/act got %b/%b/%b want %b/%b/%b",
                         i, o_hi, o_lo, o_act, e_hi(), e_cur, e_act);
            end
        end
        n_checks++;
        if (highs != 127) begin
            n_fail++; $display("FAIL ratio255_high_cycles: got %0d want 127", highs);
        end
        drain();
    endtask

    task automatic test_ratio_change();
        set_r(0, 6);
        CLK_EN = 2'b01;
        cycle();
        set_r(0, 3);
        for (int i = 0; i < 14; i++) begin
            cycle();
            n_checks++;
            if ({o_hi, o_lo, o_act} !== {e_hi(), e_cur, e_act}) begin
                n_fail++;
                $display("FAIL ratio_change cyc %0d: hi/lo/act got %b/%b/%b want %b/%b/%b",
                         i, o_hi, o_lo, o_act, e_hi(), e_cur, e_act);
            end
        end
        drain();
    endtask

    task automatic test_clean_stop();
        int highs;
        set_r(0, 8);
        CLK_EN = 2'b01;
        cycle();
        cycle();
        CLK_EN = 2'b00;          // dropped in the middle of the high phase
        highs = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            highs += int'(o_lo[0]);
            n_checks++;
            if ({o_hi, o_lo, o_act} !== {e_hi(), e_cur, e_act}) begin
                n_fail++;
                $display("FAIL clean_stop cyc %0d: hi/lo/act got %b/%b/%b want %b/%b/%b",
                         i, o_hi, o_lo, o_act, e_hi(), e_cur, e_act);
            end
        end
        n_checks++;
        if (highs != 2) begin
            n_fail++; $display("FAIL clean_stop_high_tail: got %0d want 2", highs);
        end
        cycle();
        n_checks++;
        if (o_act[0] !== 1'b0 || o_hi[0] !== 1'b0 || o_lo[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_stop_idle: act/hi/lo got %b/%b/%b want 0/0/0", o_act[0], o_hi[0], o_lo[0]);
        end
    endtask

    task automatic test_bypass();
        int plan_r [5] = '{1, 4, 0, 4, 4};
        int plan_n [5] = '{6, 10, 6, 6, 6};
        set_r(1, plan_r[0]);
        CLK_EN = 2'b10;
        for (int s = 0; s < 5; s++) begin
            set_r(1, plan_r[s]);
            if (s == 4) CLK_EN = 2'b00;
            for (int i = 0; i < plan_n[s]; i++) begin
                cycle();
                n_checks++;
                if ({o_hi, o_lo, o_act} !== {e_hi(), e_cur, e_act}) begin
                    n_fail++;
                    $display("FAIL bypass step %0d cyc %0d: hi/lo/act got %b/%b/%b want %b/%b/%b",
                             s, i, o_hi, o_lo, o_act, e_hi(), e_cur, e_act);
                end
            end
            if (s == 0) begin
                n_checks++;
                if (o_hi[1] !== 1'b1 || o_lo[1] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bypass_track: hi/lo got %b/%b want 1/0", o_hi[1], o_lo[1]);
                end
            end
        end
        drain();
    endtask

    task automatic test_reset_bypass();
        set_r(0, 1);
        CLK_EN = 2'b01;
        cycle();
        cycle();
        cycle();
        @(posedge Ref_CLK);
        #2;
        n_checks++;
        if (Div_CLK[0] !== 1'b1) begin
            n_fail++; $display("FAIL rst_byp_pre: clk got %b want 1", Div_CLK[0]);
        end
        RST = 1'b0;
        #1;
        n_checks++;
        if (Div_CLK !== '0 || Div_Active !== '0) begin
            n_fail++;
            $display("FAIL rst_byp_async: clk/act got %b/%b want 00/00", Div_CLK, Div_Active);
        end
        model_reset();
        CLK_EN = 2'b00;
        @(negedge Ref_CLK);
        #2;
        RST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_checks++;
            if ({o_hi, o_lo, o_act} !== {e_hi(), e_cur, e_act}) begin
                n_fail++;
                $display("FAIL rst_byp_after cyc %0d: hi/lo/act got %b/%b/%b want %b/%b/%b",
                         i, o_hi, o_lo, o_act, e_hi(), e_cur, e_act);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < CH; k++) begin
                if ($urandom_range(0, 7) == 0) set_r(k, int'($urandom_range(0, 9)));
                if ($urandom_range(0, 15) == 0) CLK_EN[k] = ~CLK_EN[k];
            end
            cycle();
            n_checks++;
            if ({o_hi, o_lo, o_act} !== {e_hi(), e_cur, e_act}) begin
                n_fail++;
                $display("FAIL random cyc %0d: hi/lo/act got %b/%b/%b want %b/%b/%b",
                         i, o_hi, o_lo, o_act, e_hi(), e_cur, e_act);
            end
        end
        drain();
    endtask

`ifdef CLK_DIV_TICK_EN
    task automatic test_tick();
        int ticks;
        set_r(0, 3);
        set_r(1, 1);
        CLK_EN = 2'b11;
        ticks = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            ticks += int'(o_tick[0]);
            n_checks++;
            if (o_tick !== e_tick || o_lo !== e_cur) begin
                n_fail++;
                $display("FAIL tick cyc %0d: tick/lo got %b/%b want %b/%b", i, o_tick, o_lo, e_tick, e_cur);
            end
        end
        n_checks++;
        if (ticks != 4) begin
            n_fail++; $display("FAIL tick_count: got %0d want 4", ticks);
        end
        drain();
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_even_ratio();
        test_odd_ratio();
        test_ratio_change();
        test_clean_stop();
        test_bypass();
        test_reset_bypass();
        test_random();
`ifdef CLK_DIV_TICK_EN
        test_tick();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
